reg_file: RTL and testbench



---
 rtl/reg_file_pkg.sv | 18 +
 rtl/reg_file_if.sv | 15 +
 rtl/reg_file_cell.sv | 15 +
 rtl/reg_file.sv | 27 ++
 tb/tb_reg_file.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the 8 x 16-bit general-purpose register file.
// The decoder and the control unit both use reg_addr_t.
package reg_file_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // Write strobe per register: one bit set for addr, or none when the write is disabled.
  function automatic logic [NUM_REGS-1:0] wr_decode(reg_addr_t addr, logic en);
    logic [NUM_REGS-1:0] sel;
    sel = '0;
    if (en) sel[addr] = 1'b1;
    return sel;
  endfunction
endpackage

// File: rtl/reg_file_if.sv
// Register file bus: write port from writeback, two read ports to the ALU operands.
interface reg_file_if;
  import reg_file_pkg::*;

  reg_addr_t DEST;
  reg_addr_t SRC0;
  reg_addr_t SRC1;
  reg_data_t w_in;
  logic      w_en;
  reg_data_t op0;
  reg_data_t op1;

  modport master (output DEST, SRC0, SRC1, w_in, w_en, input op0, op1);
  modport slave  (input DEST, SRC0, SRC1, w_in, w_en, output op0, op1);
endinterface

// File: rtl/reg_file_cell.sv
// One DATA_W storage register with an async active-high clear and a load enable.
module reg_file_cell
  import reg_file_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      ld,
  input  reg_data_t d,
  output reg_data_t q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= '0;
    else if (ld) q <= d;
  end
endmodule

// File: rtl/reg_file.sv
// Eight-entry register file: one synchronous write port, two combinational read ports.
// Reads show the stored value only; a same-cycle write is visible after the edge.
module reg_file
  import reg_file_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  reg_file_if.slave bus
);
  logic [NUM_REGS-1:0]             wr_sel;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  assign wr_sel = wr_decode(bus.DEST, bus.w_en);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
    reg_file_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .ld    (wr_sel[i]),
      .d     (bus.w_in),
      .q     (regs[i])
    );
  end

  assign bus.op0 = regs[bus.SRC0];
  assign bus.op1 = regs[bus.SRC1];
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: expected operands are queued as stimulus is applied
// and popped when the read ports are sampled.
`timescale 1ns/1ps
module tb_reg_file;
  import reg_file_pkg::*;

  logic clk = 1'b0;
  logic reset;
  reg_file_if bus ();

  reg_file dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  reg_data_t exp_q[$];

  task automatic cmp(input string tag, input reg_data_t obs);
    reg_data_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: observed %h but scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  // Queue the expected operands, then sample both ports shortly after.
  task automatic rd(input string tag, input reg_addr_t s0, input reg_addr_t s1,
                    input reg_data_t e0, input reg_data_t e1);
    bus.SRC0 = s0;
    bus.SRC1 = s1;
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    #0.4;
    cmp({tag, "/op0"}, bus.op0);
    cmp({tag, "/op1"}, bus.op1);
  endtask

  task automatic wr(input reg_addr_t dest, input reg_data_t data, input logic en);
    @(negedge clk);
    bus.DEST = dest;
    bus.w_in = data;
    bus.w_en = en;
    @(posedge clk);
    #1;
    bus.w_en = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    bus.DEST = '0;
    bus.SRC0 = '0;
    bus.SRC1 = '0;
    bus.w_in = '0;
    bus.w_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < NUM_REGS; a++)
      rd("reset_init", reg_addr_t'(a), reg_addr_t'(NUM_REGS - 1 - a), 16'h0000, 16'h0000);

    @(negedge clk);
    reset = 1'b0;
    wr(3'd1, 16'hAAAA, 1'b1);
    wr(3'd3, 16'hCCCC, 1'b1);
    rd("pre_async", 3'd1, 3'd3, 16'hAAAA, 16'hCCCC);

    // Asynchronous clear partway through the high phase, checked before the next edge.
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int a = 0; a < NUM_REGS; a++)
      rd("async_reset", reg_addr_t'(a), reg_addr_t'(a), 16'h0000, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    wr(3'd1, 16'hAAAA, 1'b1);
    wr(3'd3, 16'hCCCC, 1'b1);
    wr(3'd4, 16'hDDDD, 1'b1);
    wr(3'd5, 16'hEEEE, 1'b1);
    wr(3'd6, 16'hFFFF, 1'b1);
    rd("rb_r1", 3'd1, 3'd1, 16'hAAAA, 16'hAAAA);
    rd("rb_r3", 3'd3, 3'd3, 16'hCCCC, 16'hCCCC);
    rd("rb_r4", 3'd4, 3'd4, 16'hDDDD, 16'hDDDD);
    rd("rb_r5", 3'd5, 3'd5, 16'hEEEE, 16'hEEEE);
    rd("rb_r6", 3'd6, 3'd6, 16'hFFFF, 16'hFFFF);

    wr(3'd2, 16'hBBBB, 1'b0);
    rd("disabled_wr", 3'd2, 3'd4, 16'h0000, 16'hDDDD);
    rd("untouched", 3'd0, 3'd7, 16'h0000, 16'h0000);

    rd("dual_read", 3'd6, 3'd4, 16'hFFFF, 16'hDDDD);
    rd("same_addr", 3'd1, 3'd1, 16'hAAAA, 16'hAAAA);

    // Pending write to R3 must not bypass onto the read ports before the edge.
    @(negedge clk);
    bus.DEST = 3'd3;
    bus.w_in = 16'h1234;
    bus.w_en = 1'b1;
    rd("no_bypass_pre", 3'd3, 3'd3, 16'hCCCC, 16'hCCCC);
    @(posedge clk);
    #1;
    bus.w_en = 1'b0;
    rd("no_bypass_post", 3'd3, 3'd5, 16'h1234, 16'hEEEE);

    // Reset and write at the same edge: reset wins.
    @(negedge clk);
    reset    = 1'b1;
    bus.DEST = 3'd7;
    bus.w_in = 16'h5555;
    bus.w_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    bus.w_en = 1'b0;
    rd("rst_vs_wr", 3'd7, 3'd3, 16'h0000, 16'h0000);

    // Write at the first edge after deassertion lands; R0 is writable.
    bus.DEST = 3'd0;
    bus.w_in = 16'h0F0F;
    bus.w_en = 1'b1;
    @(posedge clk);
    #1;
    bus.w_en = 1'b0;
    rd("post_rst_wr", 3'd0, 3'd6, 16'h0F0F, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no completion, required finish before 20000ns");
    $fatal(1, "timeout");
  end
endmodule
